// File: rtl/multisim_pull_mux_pkg.sv
// Shared types and helpers for the pulled-stream round-robin mux.
package multisim_pull_mux_pkg;

    // IDLE: no channel owns the output; HOLD: a channel is mid-burst
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int BURST_CNT_W = 8;

    // Channel index width; a two-channel or smaller mux still needs one bit
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multisim_rr_pick.sv
// Rotating-priority picker: returns the first asserted request found by
// searching start, start+1, ... (mod NUM_CH). Purely combinational.
module multisim_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   start,
    output logic [CH_W-1:0]   grant,
    output logic              grant_vld
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest request wins
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NUM_CH;
            if (req[idx]) begin
                grant     = CH_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multisim_pull_rr_mux.sv
// Round-robin merge of NUM_CH pulled valid/ready streams into one registered
// output stream tagged with the source channel. A channel may hold the output
// for at most MAX_BURST consecutive beats before the grant rotates.
// Optional build macro MULTISIM_PULL_RR_MUX_STATS_EN adds saturating
// per-channel beat counters and an output-stall counter.
module multisim_pull_rr_mux
    import multisim_pull_mux_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int MAX_BURST  = 8,
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     in_vld,
    output logic [NUM_CH-1:0]     in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_CH],
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]       out_ch_id
`ifdef MULTISIM_PULL_RR_MUX_STATS_EN
    ,
    output logic [31:0]           stat_beats [NUM_CH],
    output logic [31:0]           stat_stall
`endif
);

    state_t                 state, state_nxt;
    logic [CH_W-1:0]        cur, cur_nxt;
    logic [CH_W-1:0]        ptr, ptr_nxt;
    logic [BURST_CNT_W-1:0] burst_cnt, burst_nxt;

    logic                   load;
    logic                   keep;
    logic [CH_W-1:0]        pick_start;
    logic [CH_W-1:0]        grant;
    logic                   grant_vld;

    function automatic logic [CH_W-1:0] next_idx(input logic [CH_W-1:0] i);
        if (int'(i) == NUM_CH - 1) return '0;
        return i + CH_W'(1);
    endfunction

    assign load = !out_vld || out_rdy;
    // The current owner keeps the grant only while it still requests and has burst budget
    assign keep = (state == HOLD) && in_vld[cur] && (burst_cnt < BURST_CNT_W'(MAX_BURST));

    // Pick where the rotating search begins; starting at cur+1 still wraps back to cur last
    always_comb begin
        pick_start = ptr;
        if (state == HOLD) pick_start = keep ? cur : next_idx(cur);
    end

    multisim_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req       (in_vld),
        .start     (pick_start),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    // Next-state and ready generation; arbitration state only moves when the output slot loads
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        ptr_nxt   = ptr;
        burst_nxt = burst_cnt;
        in_rdy    = '0;
        if (load) begin
            if (grant_vld) begin
                in_rdy[grant] = rst_n;
                state_nxt     = HOLD;
                cur_nxt       = grant;
                ptr_nxt       = next_idx(grant);
                burst_nxt     = keep ? burst_cnt + BURST_CNT_W'(1) : BURST_CNT_W'(1);
            end else begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
        end
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Single output slot; refills whenever it is empty or being drained this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_ch_id <= '0;
        end else if (load) begin
            out_vld <= grant_vld;
            if (grant_vld) begin
                out_data  <= in_data[grant];
                out_ch_id <= grant;
            end
        end
    end

`ifdef MULTISIM_PULL_RR_MUX_STATS_EN
    // Saturating beat-per-channel and stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) stat_beats[c] <= '0;
            stat_stall <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_vld[c] && in_rdy[c] && (stat_beats[c] != '1))
                    stat_beats[c] <= stat_beats[c] + 32'd1;
            end
            if (out_vld && !out_rdy && (stat_stall != '1))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multisim_pull_rr_mux.sv
// Directed scoreboard bench for multisim_pull_rr_mux (NUM_CH=4, MAX_BURST=3).
// Source payloads are {channel, per-channel sequence number}.
module tb_multisim_pull_rr_mux;

    localparam int NUM_CH     = 4;
    localparam int DATA_WIDTH = 64;
    localparam int MAX_BURST  = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_CH-1:0]     in_vld;
    logic [NUM_CH-1:0]     in_rdy;
    logic [DATA_WIDTH-1:0] in_data [NUM_CH];
    logic                  out_vld;
    logic                  out_rdy;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_ch_id;
`ifdef MULTISIM_PULL_RR_MUX_STATS_EN
    logic [31:0]           stat_beats [NUM_CH];
    logic [31:0]           stat_stall;
`endif

    always #5 clk = ~clk;

    multisim_pull_rr_mux #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_data    (in_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_ch_id  (out_ch_id)
`ifdef MULTISIM_PULL_RR_MUX_STATS_EN
        ,
        .stat_beats (stat_beats),
        .stat_stall (stat_stall)
`endif
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int          exp_q [$];
    int          src_cnt [NUM_CH];
    int          exp_cnt [NUM_CH];
    int          xfer [NUM_CH];
    int          stalls = 0;
    int          beats  = 0;
    int          b0;
    logic        prev_vld;
    logic        prev_rdy;
    logic [63:0] prev_data;
    logic [1:0]  prev_ch;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push(input int ch, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(ch);
    endtask

    // One clock cycle: drive sources and out_rdy, score the output, advance sources
    task automatic cyc(input logic [3:0] mask, input logic rdy);
        int ch;
        in_vld  = mask;
        out_rdy = rdy;
        for (int c = 0; c < NUM_CH; c++) in_data[c] = {8'(c), 56'(src_cnt[c])};
        #1;
        check("rdy_onehot0", 64'($onehot0(in_rdy)), 64'd1);
        if (prev_vld && !prev_rdy) begin
            check("hold_vld", 64'(out_vld), 64'd1);
            check("hold_data", out_data, prev_data);
            check("hold_ch", 64'(out_ch_id), 64'(prev_ch));
        end
        if (out_vld && !out_rdy) begin
            check("stall_in_rdy", 64'(in_rdy), 64'd0);
            stalls++;
        end
        if (out_vld && out_rdy) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                ch = exp_q.pop_front();
                check("beat_ch", 64'(out_ch_id), 64'(ch));
                check("beat_data", out_data, {8'(ch), 56'(exp_cnt[ch])});
                exp_cnt[ch]++;
                beats++;
            end
        end
        prev_vld  = out_vld;
        prev_rdy  = out_rdy;
        prev_data = out_data;
        prev_ch   = out_ch_id;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_vld[c] && in_rdy[c]) begin
                src_cnt[c]++;
                xfer[c]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) cyc(4'b0000, 1'b1);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            src_cnt[c] = 0;
            exp_cnt[c] = 0;
            xfer[c]    = 0;
        end
        prev_vld = 1'b0;
        prev_rdy = 1'b1;
        prev_data = '0;
        prev_ch  = '0;

        // Reset held with random inputs
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_vld  = 4'($urandom_range(1, 15));
            out_rdy = 1'($urandom);
            for (int c = 0; c < NUM_CH; c++) in_data[c] = {$urandom, $urandom};
            #1;
            check("rst_out_vld", 64'(out_vld), 64'd0);
            check("rst_out_data", out_data, 64'd0);
            check("rst_out_ch_id", 64'(out_ch_id), 64'd0);
            check("rst_in_rdy", 64'(in_rdy), 64'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // All channels valid: bursts of MAX_BURST rotating 0,1,2,3,0,...
        for (int k = 0; k < 24; k++) exp_q.push_back((k / MAX_BURST) % NUM_CH);
        b0 = beats;
        for (int k = 0; k < 24; k++) cyc(4'b1111, 1'b1);
        check("all_vld_beats", 64'(beats - b0), 64'd23);
        drain("all_vld_drain");
        check("all_vld_idle", 64'(dut.state), 64'd0);

        // Lone requester re-granted across the burst boundary with no bubble
        push(2, 9);
        b0 = beats;
        for (int k = 1; k <= 9; k++) begin
            cyc(4'b0100, 1'b1);
            check("lone_burst_cnt", 64'(dut.burst_cnt), 64'(((k - 1) % MAX_BURST) + 1));
        end
        check("lone_beats", 64'(beats - b0), 64'd8);
        drain("lone_drain");

        // Output stall with channels 0 and 1 valid (ptr=3, so channel 0 first)
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(1);
        b0 = stalls;
        for (int k = 0; k < 2; k++) cyc(4'b0011, 1'b1);
        for (int k = 0; k < 5; k++) cyc(4'b0011, 1'b0);
        check("stall_burst_cnt", 64'(dut.burst_cnt), 64'd2);
        check("stall_cycles", 64'(stalls - b0), 64'd5);
        for (int k = 0; k < 8; k++) cyc(4'b0011, 1'b1);
        drain("stall_drain");

        // Channel 1 drops mid-burst while channel 3 requests (ptr=2, so channel 1 first)
        push(1, 2); push(3, 3); push(1, 3); push(3, 1);
        for (int k = 0; k < 2; k++) cyc(4'b0010, 1'b1);
        cyc(4'b1000, 1'b1);
        check("drop_burst_cnt", 64'(dut.burst_cnt), 64'd1);
        for (int k = 0; k < 6; k++) cyc(4'b1010, 1'b1);
        drain("drop_drain");

`ifdef MULTISIM_PULL_RR_MUX_STATS_EN
        for (int c = 0; c < NUM_CH; c++) check("stat_beats", 64'(stat_beats[c]), 64'(xfer[c]));
        check("stat_stall", 64'(stat_stall), 64'(stalls));
`endif

        // Reset asserted mid-burst drops the held beat and clears arbitration
        push(0, 2);
        for (int k = 0; k < 2; k++) cyc(4'b1111, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_vld", 64'(out_vld), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
        check("mid_rst_burst_cnt", 64'(dut.burst_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) exp_cnt[c] = src_cnt[c];
        prev_vld = 1'b0;
        push(0, 1);
        cyc(4'b1111, 1'b1);
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
